// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction prefetch unit. A fetch PC register addresses a combinational
// instruction memory every cycle. Each fetched {pc, instr} pair is pushed into
// a small circular prefetch queue, and the queue head is presented to the
// consumer with a valid/ready handshake. A redirect flushes the queue and
// restarts fetching at the target. A misaligned redirect target parks the unit
// in a sticky FAULT state until reset.
//
// Parameters
//   RESET_PC  fetch address loaded on reset
//   DEPTH     prefetch queue entries (power of two, >= 2)
//
// Ports
//   CLK            sole clock, rising edge
//   RESET          synchronous, active-high reset
//   imem_addr_o    byte address to instruction memory (straight from fetch_pc)
//   imem_instr_i   instruction word for imem_addr_o, same cycle
//   redirect_i     taken branch / jump: flush and refetch
//   redirect_pc_i  redirect target byte address
//   instr_o        instruction at queue head
//   pc_o           byte address of instr_o
//   valid_o        queue head holds a valid instruction
//   ready_i        consumer accepts the head this cycle
//   fault_o        sticky misaligned-redirect fault
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        fault_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t        state_q,    state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW:0]   count_q,    count_d;

    logic          push;
    logic          pop;

    // Queue payload; deliberately not reset, validity is tracked by count_q.
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = 1'b0;

        case (state_q)
            RUN: begin
                if (redirect_i) begin
                    // Redirect wins over any handshake this cycle.
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    if (redirect_pc_i[1:0] == 2'b00) begin
                        fetch_pc_d = redirect_pc_i;
                    end else begin
                        state_d = FAULT;
                    end
                end else begin
                    pop  = (count_q != '0) && ready_i;
                    // A pop frees a slot in the same cycle, so a full queue
                    // still streams at one instruction per cycle.
                    push = (count_q != FULL_CNT) || pop;

                    if (push) begin
                        wr_ptr_d   = wr_ptr_q + PTR_ONE;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end

                    if (push && !pop) begin
                        count_d = count_q + CNT_ONE;
                    end else if (pop && !push) begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end
            default: begin
                // FAULT: frozen until reset.
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= imem_instr_i;
        end
    end

    assign imem_addr_o = fetch_pc_q;
    assign instr_o     = instr_mem[rd_ptr_q];
    assign pc_o        = pc_mem[rd_ptr_q];
    // FAULT always flushes the queue on entry, so count_q alone gives valid.
    assign valid_o     = (count_q != '0);
    assign fault_o     = (state_q == FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Bench for instr_fetch. A reference model keeps the fetch address, a sticky
// fault flag and a queue of expected {pc, instr} entries; a monitor compares
// the DUT outputs against that queue on the falling edge and retires entries
// the consumer accepts. Directed sequences cover the corner cases, followed by
// a randomized run.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        CLK;
    logic        RESET;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        fault_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] model_pc    = 32'h0;
    logic        model_fault = 1'b0;
    logic        started     = 1'b0;

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .fault_o       (fault_o)
    );

    // Instruction memory: mem[i] = i (word index).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    assign imem_instr_i = mem_word(imem_addr_o);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model, advanced on every rising edge from the driven inputs.
    // The monitor has already retired an accepted head before this runs, so
    // "room in the queue" is simply size < DEPTH.
    always @(posedge CLK) begin
        if (RESET) begin
            started     <= 1'b1;
            model_pc    <= RESET_PC;
            model_fault <= 1'b0;
            sb.delete();
        end else if (started && !model_fault) begin
            if (redirect_i) begin
                sb.delete();
                if (redirect_pc_i[1:0] == 2'b00) model_pc <= redirect_pc_i;
                else                             model_fault <= 1'b1;
            end else if (sb.size() < DEPTH) begin
                sb.push_back('{pc: model_pc, instr: mem_word(model_pc)});
                model_pc <= model_pc + 32'd4;
            end
        end
    end

    // Monitor: inputs seen here are those for the next rising edge.
    always @(negedge CLK) begin
        if (started) begin
            chk("imem_addr", imem_addr_o, model_pc);
            chk("fault", 32'(fault_o), 32'(model_fault));
            chk("valid", 32'(valid_o), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("pc", pc_o, sb[0].pc);
                chk("instr", instr_o, sb[0].instr);
                if (ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic rst, input logic red, input logic [31:0] rpc,
                         input logic rdy);
        RESET         = rst;
        redirect_i    = red;
        redirect_pc_i = rpc;
        ready_i       = rdy;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] rpc;
        int          r;

        // Streaming from reset with the consumer always ready.
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 32'h80, 1'b1);
        idle(10, 1'b1);

        // Consumer stalled: queue fills and fetch stalls, then drains in order.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        idle(4, 1'b0);
        idle(6, 1'b1);

        // Redirect while full.
        idle(3, 1'b0);
        drive(1'b0, 1'b1, 32'h40, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Address wrap at the top of memory.
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        idle(4, 1'b1);

        // Mixed stalls.
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 32'h0, 1'($urandom_range(1, 0)));

        // Misaligned redirect, further redirects ignored, reset clears.
        drive(1'b0, 1'b1, 32'h42, 1'b1);
        drive(1'b0, 1'b1, 32'h100, 1'b1);
        drive(1'b0, 1'b1, 32'h43, 1'b0);
        idle(3, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        idle(3, 1'b1);

        // Reset with full queue and a coincident redirect.
        idle(3, 1'b0);
        drive(1'b1, 1'b1, 32'h200, 1'b1);
        idle(4, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(99, 0);
            if (r < 1) begin
                drive(1'b1, 1'($urandom_range(1, 0)), $urandom, 1'($urandom_range(1, 0)));
            end else if (r < 6) begin
                rpc = $urandom;
                if ($urandom_range(4, 0) != 0) rpc[1:0] = 2'b00;
                if ($urandom_range(9, 0) == 0) rpc = 32'hFFFF_FFF8;
                drive(1'b0, 1'b1, rpc, 1'($urandom_range(1, 0)));
            end else begin
                drive(1'b0, 1'b0, $urandom, ($urandom_range(9, 0) < 7));
            end
        end

        idle(3, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
